// File: rtl/adc_capture_if.sv
// Bundle of the capture buffer's data, control, readout and status signals.
//
// Handshake semantics: there is no valid/ready pair on this block. `arm` and
// `abort` are single-cycle command strobes sampled on every clk_adc edge;
// `arm` is only accepted in IDLE or DONE, `abort` always wins. The read port
// is an always-ready pipeline: a new {rd_addr, rd_ch} is accepted every
// cycle and its data appears on rd_data one edge later.
interface adc_capture_if #(
    parameter int N_CH   = 16,
    parameter int N_BITS = 8,
    parameter int DEPTH  = 256
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_BITS-1:0] adcout [N_CH-1:0];
    logic [N_CH-1:0]   adcout_sign;
    logic              mode;
    logic [AW-1:0]     pretrig_len;
    logic [7:0]        decim;
    logic              arm;
    logic              abort;
    logic              trig;
    logic [AW-1:0]     rd_addr;
    logic [CW-1:0]     rd_ch;
    logic [N_BITS:0]   rd_data;
    logic              busy;
    logic              done;
    logic [AW-1:0]     start_addr;
    logic [2:0]        state_dbg;

    modport slave (
        input  adcout, adcout_sign, mode, pretrig_len, decim,
        input  arm, abort, trig, rd_addr, rd_ch,
        output rd_data, busy, done, start_addr, state_dbg
    );

    modport master (
        output adcout, adcout_sign, mode, pretrig_len, decim,
        output arm, abort, trig, rd_addr, rd_ch,
        input  rd_data, busy, done, start_addr, state_dbg
    );
endinterface

// File: rtl/adc_capture_buffer.sv
// Triggerable capture memory for interleaved ADC samples. Stores DEPTH frames
// of N_CH {sign, magnitude} samples, with optional decimation and a
// pre-trigger ring mode that keeps history ahead of the trigger edge.
module adc_capture_buffer #(
    parameter int N_CH   = 16,
    parameter int N_BITS = 8,
    parameter int DEPTH  = 256
) (
    input  logic           clk_adc,
    input  logic           rst,
    adc_capture_if.slave   cap
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = N_BITS + 1;
    localparam int unsigned DEPTH_U = DEPTH;
    localparam logic [AW:0] DEPTH_W = DEPTH_U[AW:0];

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PREFILL   = 3'd1,
        S_WAIT_TRIG = 3'd2,
        S_CAPTURE   = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic          r_trig_q;
    logic          w_trig_edge;

    logic [7:0]    r_dec_cnt;
    logic [7:0]    r_decim;
    logic          w_sen;

    logic          r_mode;
    logic [AW-1:0] r_pretrig;

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] w_wr_ptr_next;
    logic [AW-1:0] r_start_addr;
    logic [AW:0]   r_cap_cnt;
    logic [AW:0]   r_fill_cnt;
    logic [AW:0]   w_cap_sum;
    logic [AW:0]   w_fill_sum;
    logic [AW:0]   w_target;

    logic          w_busy;
    logic          w_arm_ok;
    logic          w_wr_en;
    logic          w_cap_inc;

    logic [SW-1:0] r_mem [DEPTH][N_CH];
    logic [SW-1:0] r_rd_data;

    // A trig held high through reset must not look like an edge, hence r_trig_q resets to 1.
    assign w_trig_edge   = cap.trig & ~r_trig_q;
    assign w_sen         = (r_dec_cnt == 8'd0);
    assign w_busy        = (r_state == S_PREFILL) || (r_state == S_WAIT_TRIG) ||
                           (r_state == S_CAPTURE);
    assign w_arm_ok      = cap.arm && !cap.abort &&
                           ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_wr_ptr_next = r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
    assign w_target      = DEPTH_W - (r_mode ? {1'b0, r_pretrig} : {(AW+1){1'b0}});

    // Write enable and frame counters: which cycles store a frame and what they count toward.
    always_comb begin
        w_wr_en = 1'b0;
        case (r_state)
            S_PREFILL:   w_wr_en = w_sen;
            S_WAIT_TRIG: w_wr_en = w_sen && (r_mode || w_trig_edge);
            S_CAPTURE:   w_wr_en = w_sen;
            default:     w_wr_en = 1'b0;
        endcase
        if (cap.abort || rst) begin
            w_wr_en = 1'b0;
        end
        w_cap_inc  = w_wr_en && ((r_state == S_CAPTURE) ||
                                 ((r_state == S_WAIT_TRIG) && w_trig_edge));
        w_cap_sum  = r_cap_cnt + {{AW{1'b0}}, w_cap_inc};
        w_fill_sum = r_fill_cnt + {{AW{1'b0}}, w_wr_en};
    end

    // Next-state logic for the capture sequencer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (cap.arm) begin
                    if (cap.mode && (cap.pretrig_len != {AW{1'b0}})) begin
                        w_state_next = S_PREFILL;
                    end else begin
                        w_state_next = S_WAIT_TRIG;
                    end
                end
            end
            S_PREFILL: begin
                if (w_wr_en && (w_fill_sum == {1'b0, r_pretrig})) begin
                    w_state_next = S_WAIT_TRIG;
                end
            end
            S_WAIT_TRIG: begin
                if (w_trig_edge) begin
                    if (w_cap_inc && (w_cap_sum == w_target)) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_CAPTURE;
                    end
                end
            end
            S_CAPTURE: begin
                if (w_cap_inc && (w_cap_sum == w_target)) begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        if (cap.abort) begin
            w_state_next = S_IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk_adc) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Configuration snapshot, decimation, write pointer and capture bookkeeping.
    always_ff @(posedge clk_adc) begin
        if (rst) begin
            r_trig_q     <= 1'b1;
            r_dec_cnt    <= 8'd0;
            r_decim      <= 8'd0;
            r_mode       <= 1'b0;
            r_pretrig    <= {AW{1'b0}};
            r_wr_ptr     <= {AW{1'b0}};
            r_cap_cnt    <= {(AW+1){1'b0}};
            r_fill_cnt   <= {(AW+1){1'b0}};
            r_start_addr <= {AW{1'b0}};
        end else begin
            r_trig_q <= cap.trig;
            if (w_arm_ok) begin
                r_mode     <= cap.mode;
                r_pretrig  <= cap.pretrig_len;
                r_decim    <= cap.decim;
                r_dec_cnt  <= 8'd0;
                r_wr_ptr   <= {AW{1'b0}};
                r_cap_cnt  <= {(AW+1){1'b0}};
                r_fill_cnt <= {(AW+1){1'b0}};
            end else begin
                if (w_busy) begin
                    r_dec_cnt <= (r_dec_cnt == r_decim) ? 8'd0 : r_dec_cnt + 8'd1;
                end
                if (w_wr_en) begin
                    r_wr_ptr <= w_wr_ptr_next;
                end
                if (r_state == S_PREFILL) begin
                    r_fill_cnt <= w_fill_sum;
                end
                r_cap_cnt <= w_cap_sum;
                // The DONE entry edge always carries the final write, so the
                // post-increment pointer is the oldest valid frame.
                if ((w_state_next == S_DONE) && (r_state != S_DONE)) begin
                    r_start_addr <= w_wr_ptr_next;
                end
            end
        end
    end

    // Frame storage; never cleared so a dump survives reset.
    always_ff @(posedge clk_adc) begin
        if (w_wr_en) begin
            for (int c = 0; c < N_CH; c++) begin
                r_mem[r_wr_ptr][c] <= {cap.adcout_sign[c], cap.adcout[c]};
            end
        end
    end

    // Registered readout; a same-cycle write to the read address returns the old word.
    always_ff @(posedge clk_adc) begin
        if (rst) begin
            r_rd_data <= {SW{1'b0}};
        end else begin
            r_rd_data <= r_mem[cap.rd_addr][cap.rd_ch];
        end
    end

    assign cap.rd_data    = r_rd_data;
    assign cap.busy       = w_busy;
    assign cap.done       = (r_state == S_DONE);
    assign cap.start_addr = r_start_addr;
    assign cap.state_dbg  = r_state;
endmodule

// File: tb/tb_adc_capture_buffer.sv
// Directed bench for adc_capture_buffer with N_CH=4, N_BITS=8, DEPTH=16.
// Each input frame carries adcout[c] = frame counter + c, sign = counter bit 0.
module tb_adc_capture_buffer;
    localparam int N_CH   = 4;
    localparam int N_BITS = 8;
    localparam int DEPTH  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] fc = 32'd0;
    logic [31:0] f4 = 32'd0;

    always #5 clk = ~clk;

    adc_capture_if #(.N_CH(N_CH), .N_BITS(N_BITS), .DEPTH(DEPTH)) cap ();

    adc_capture_buffer #(.N_CH(N_CH), .N_BITS(N_BITS), .DEPTH(DEPTH)) dut (
        .clk_adc (clk),
        .rst     (rst),
        .cap     (cap)
    );

    function automatic logic [8:0] samp(input logic [31:0] f, input int c);
        logic [31:0] v;
        v = f + 32'(c);
        return {f[0], v[7:0]};
    endfunction

    task automatic drive_frame();
        for (int c = 0; c < N_CH; c++) begin
            logic [31:0] t;
            t = fc + 32'(c);
            cap.adcout[c]      = t[7:0];
            cap.adcout_sign[c] = fc[0];
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        fc = fc + 32'd1;
        drive_frame();
    endtask

    task automatic arm_capture(input logic m, input logic [3:0] p, input logic [7:0] d);
        cap.mode        = m;
        cap.pretrig_len = p;
        cap.decim       = d;
        cap.arm         = 1'b1;
        tick();
        cap.arm         = 1'b0;
    endtask

    // Bounded wait for done; n = edges after the trigger cycle, -1 on timeout.
    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (cap.done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_tests++; if (cap.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", cap.busy); end
        n_tests++; if (cap.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", cap.done); end
        n_tests++; if (cap.start_addr !== 4'd0) begin n_fail++; $display("FAIL reset_start got=%0d want=0", cap.start_addr); end
        n_tests++; if (cap.rd_data !== 9'd0) begin n_fail++; $display("FAIL reset_rd_data got=%h want=0", cap.rd_data); end
        n_tests++; if (cap.state_dbg !== 3'd0) begin n_fail++; $display("FAIL reset_state got=%0d want=0", cap.state_dbg); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_mode0_basic();
        int n;
        logic [31:0] f;
        arm_capture(1'b0, 4'd0, 8'd0);
        n_tests++; if (cap.busy !== 1'b1) begin n_fail++; $display("FAIL t1_busy_after_arm got=%b want=1", cap.busy); end
        repeat (4) tick();
        cap.trig = 1'b1;
        f = fc;
        wait_done(n);
        n_tests++; if (n !== 16) begin n_fail++; $display("FAIL t1_done_latency got=%0d want=16", n); end
        n_tests++; if (cap.start_addr !== 4'd0) begin n_fail++; $display("FAIL t1_start_addr got=%0d want=0", cap.start_addr); end
        n_tests++; if (cap.busy !== 1'b0) begin n_fail++; $display("FAIL t1_busy_at_done got=%b want=0", cap.busy); end
        cap.trig = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            cap.rd_addr = 4'(a);
            cap.rd_ch   = 2'(a % 4);
            tick();
            n_tests++;
            if (cap.rd_data !== samp(f + 32'(a), a % 4)) begin
                n_fail++;
                $display("FAIL t1_read addr=%0d got=%h want=%h", a, cap.rd_data, samp(f + 32'(a), a % 4));
            end
        end
    endtask

    task automatic test_pretrig_ring();
        int n;
        logic [31:0] f;
        logic [3:0] sa;
        arm_capture(1'b1, 4'd4, 8'd0);
        repeat (30) tick();
        cap.trig = 1'b1;
        f = fc;
        wait_done(n);
        cap.trig = 1'b0;
        n_tests++; if (n !== 12) begin n_fail++; $display("FAIL t2_done_latency got=%0d want=12", n); end
        // 30 frames written before the trigger cycle: pointer 14, minus 4 pre-trigger frames.
        n_tests++; if (cap.start_addr !== 4'd10) begin n_fail++; $display("FAIL t2_start_addr got=%0d want=10", cap.start_addr); end
        for (int i = 0; i < DEPTH; i++) begin
            sa = 4'(10 + i);
            cap.rd_addr = sa;
            cap.rd_ch   = 2'((i + 1) % 4);
            tick();
            n_tests++;
            if (cap.rd_data !== samp(f - 32'd4 + 32'(i), (i + 1) % 4)) begin
                n_fail++;
                $display("FAIL t2_read idx=%0d got=%h want=%h", i, cap.rd_data, samp(f - 32'd4 + 32'(i), (i + 1) % 4));
            end
        end
    endtask

    task automatic test_decimation();
        int n;
        logic [31:0] f;
        arm_capture(1'b0, 4'd0, 8'd2);
        repeat (5) tick();
        cap.trig = 1'b1;
        f = fc;
        wait_done(n);
        cap.trig = 1'b0;
        // Trigger cycle has no sample; first write one cycle later, then every 3rd.
        n_tests++; if (n !== 47) begin n_fail++; $display("FAIL t3_done_latency got=%0d want=47", n); end
        n_tests++; if (cap.start_addr !== 4'd0) begin n_fail++; $display("FAIL t3_start_addr got=%0d want=0", cap.start_addr); end
        for (int a = 0; a < DEPTH; a++) begin
            cap.rd_addr = 4'(a);
            cap.rd_ch   = 2'(a % 4);
            tick();
            n_tests++;
            if (cap.rd_data !== samp(f + 32'd1 + 32'(3 * a), a % 4)) begin
                n_fail++;
                $display("FAIL t3_read addr=%0d got=%h want=%h", a, cap.rd_data, samp(f + 32'd1 + 32'(3 * a), a % 4));
            end
        end
    endtask

    task automatic test_trig_through_reset();
        int n;
        logic [31:0] f;
        cap.trig = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        arm_capture(1'b0, 4'd0, 8'd0);
        repeat (30) tick();
        n_tests++; if (cap.done !== 1'b0) begin n_fail++; $display("FAIL t4_no_done_held got=%b want=0", cap.done); end
        n_tests++; if (cap.state_dbg !== 3'd2) begin n_fail++; $display("FAIL t4_wait_state got=%0d want=2", cap.state_dbg); end
        cap.trig = 1'b0;
        tick();
        cap.trig = 1'b1;
        f = fc;
        f4 = f;
        wait_done(n);
        cap.trig = 1'b0;
        n_tests++; if (n !== 16) begin n_fail++; $display("FAIL t4_done_latency got=%0d want=16", n); end
        cap.rd_addr = 4'd9;
        cap.rd_ch   = 2'd3;
        tick();
        n_tests++; if (cap.rd_data !== samp(f + 32'd9, 3)) begin n_fail++; $display("FAIL t4_read got=%h want=%h", cap.rd_data, samp(f + 32'd9, 3)); end
    endtask

    task automatic test_abort_and_reset();
        logic [31:0] f2;
        arm_capture(1'b0, 4'd0, 8'd0);
        tick();
        cap.trig = 1'b1;
        repeat (5) tick();
        cap.abort = 1'b1;
        cap.arm   = 1'b1;
        tick();
        cap.abort = 1'b0;
        cap.arm   = 1'b0;
        n_tests++; if (cap.state_dbg !== 3'd0) begin n_fail++; $display("FAIL t5_abort_state got=%0d want=0", cap.state_dbg); end
        n_tests++; if (cap.busy !== 1'b0) begin n_fail++; $display("FAIL t5_abort_busy got=%b want=0", cap.busy); end
        n_tests++; if (cap.done !== 1'b0) begin n_fail++; $display("FAIL t5_abort_done got=%b want=0", cap.done); end
        cap.trig = 1'b0;
        tick();
        arm_capture(1'b0, 4'd0, 8'd0);
        tick();
        cap.trig = 1'b1;
        f2 = fc;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        n_tests++; if (cap.state_dbg !== 3'd0) begin n_fail++; $display("FAIL t5_rst_state got=%0d want=0", cap.state_dbg); end
        n_tests++; if (cap.busy !== 1'b0) begin n_fail++; $display("FAIL t5_rst_busy got=%b want=0", cap.busy); end
        n_tests++; if (cap.done !== 1'b0) begin n_fail++; $display("FAIL t5_rst_done got=%b want=0", cap.done); end
        n_tests++; if (cap.rd_data !== 9'd0) begin n_fail++; $display("FAIL t5_rst_rd_data got=%h want=0", cap.rd_data); end
        rst = 1'b0;
        cap.trig = 1'b0;
        tick();
        // Addresses 4 and 5 sit at the abort/reset boundary and are not checked.
        for (int a = 0; a < DEPTH; a++) begin
            if (a == 4 || a == 5) continue;
            cap.rd_addr = 4'(a);
            cap.rd_ch   = 2'(a % 4);
            tick();
            n_tests++;
            if (cap.rd_data !== samp(((a < 4) ? f2 : f4) + 32'(a), a % 4)) begin
                n_fail++;
                $display("FAIL t5_mem_keep addr=%0d got=%h want=%h", a, cap.rd_data, samp(((a < 4) ? f2 : f4) + 32'(a), a % 4));
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [31:0] f;
        logic [31:0] fr;
        arm_capture(1'b1, 4'd0, 8'd0);
        repeat (7) tick();
        cap.trig = 1'b1;
        f = fc;
        wait_done(n);
        cap.trig = 1'b0;
        n_tests++; if (n !== 16) begin n_fail++; $display("FAIL t6_done_latency got=%0d want=16", n); end
        n_tests++; if (cap.start_addr !== 4'd7) begin n_fail++; $display("FAIL t6_start_addr got=%0d want=7", cap.start_addr); end
        for (int k = 0; k < DEPTH * N_CH; k++) begin
            cap.rd_addr = 4'(k / 4);
            cap.rd_ch   = 2'(k % 4);
            tick();
            fr = f + 32'(((k / 4) + 16 - 7) % 16);
            n_tests++;
            if (cap.rd_data !== samp(fr, k % 4)) begin
                n_fail++;
                $display("FAIL t6_b2b_read addr=%0d ch=%0d got=%h want=%h", k / 4, k % 4, cap.rd_data, samp(fr, k % 4));
            end
        end
    endtask

    initial begin
        cap.mode        = 1'b0;
        cap.pretrig_len = 4'd0;
        cap.decim       = 8'd0;
        cap.arm         = 1'b0;
        cap.abort       = 1'b0;
        cap.trig        = 1'b0;
        cap.rd_addr     = 4'd0;
        cap.rd_ch       = 2'd0;
        drive_frame();

        test_reset();
        test_mode0_basic();
        test_pretrig_ring();
        test_decimation();
        test_trig_through_reset();
        test_abort_and_reset();
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
